io_bus_slave: RTL and testbench
===============================

# io_bus_slave

CPU-side front end of the I/O bus path, running on the fast accelerator clock. It accepts decoded CPU I/O cycles and posts writes through a one-deep buffer. It issues the `IOREQ`/`IORW`/`IOLDS`/`IOUDS` level request consumed by the C16M-domain PDS bus master, tracks that master's `IOACT` across the clock boundary, and returns `nDTACK` to the CPU.

## Interface
- No parameters.
- `FCLK  in  1`  fast CPU clock; sole clock of the block.
- `nRES  in  1`  reset, asynchronous and active-low.
- `IOCS  in  1`  address decode: current CPU cycle targets I/O space.
- `nAS  in  1`  CPU address strobe, active-low, FCLK-synchronous.
- `RnW  in  1`  CPU read/not-write.
- `nUDS, nLDS  in  1 each`  CPU data strobes, active-low.
- `IOACT  in  1`  master busy flag from the C16M domain; asynchronous to FCLK.
- `nDTACK  out  1`  acknowledge to CPU, active-low.
- `IOREQ  out  1`  request level to the bus master.
- `IORW  out  1`  request direction, 1 = read.
- `IOLDS, IOUDS  out  1 each`  request byte lanes, active-high.
- `ALE1  out  1`  one-cycle pulse that captures the CPU address and write data into the outbound latches.
- `IOBUSY  out  1`  high while a request is outstanding.

## Operation
- `IOACT` passes through a 2-flop synchronizer to give `IOACTs`. All handshake decisions use `IOACTs` only.
- A CPU cycle starts on the first FCLK edge where `!nAS && IOCS` holds and the cycle has not yet been accepted. The cycle is accepted when the FSM is IDLE and `IOACTs == 0`.
- On acceptance:
  - `IORW`, `IOLDS` and `IOUDS` load from `RnW`, `!nLDS` and `!nUDS`.
  - `ALE1` pulses for one cycle.
  - The FSM goes to REQ.
  - For a write, the cycle is also posted: `nDTACK` goes low on the next edge.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: `IOREQ = 1`. Leave to ACT when `IOACTs == 1`.
  - ACT: `IOREQ = 0`. Leave when `IOACTs == 0`; go to DONE for a read, to IDLE for a write.
  - DONE: one cycle. Read data is valid in the master's input latch. Assert `nDTACK = 0`, then go to IDLE.
- `nDTACK` stays low until `nAS` is sampled high, then returns high on the next edge. Exactly one acknowledge is given per CPU cycle.
- Blocking cases (posted-write buffer busy):
  - A new I/O cycle of either direction arriving while not IDLE, or while `IOACTs == 1`, is held unacknowledged until acceptance.
  - A read is never reordered ahead of a posted write.
- If `nAS` rises before acceptance, the cycle is dropped with no request. This is an aborted cycle.
- `IOBUSY = (state != IDLE) || IOACTs`.
- Reset values:
  - Outputs: `nDTACK = 1`, `IOREQ = 0`, `IORW = 1`, `IOLDS = 0`, `IOUDS = 0`, `ALE1 = 0`, `IOBUSY = 0`.
  - Internal: state = IDLE, synchronizer = 0.
- Reset mid-operation: the FSM is abandoned and `IOREQ` drops immediately. The master completes its own cycle independently. After reset, no request is issued until `IOACTs` has been observed low.

## Timing
- Edge numbering: accept at edge N.
  - `ALE1` is high during cycle N+1.
  - `IOREQ` rises at N+1.
  - A posted write has `nDTACK` low at N+1.
- `IOREQ` falls 1 edge after `IOACTs` rises, i.e. 3 FCLK edges after `IOACT` rises at the synchronizer input.
- Read acknowledge: `nDTACK` falls 2 edges after `IOACTs` falls (ACT→DONE, then DONE asserts).
- Back-to-back: after a posted write, the next cycle is accepted on the edge after ACT→IDLE, provided `IOACTs == 0`.
- `IOREQ` is never high at the same time as `IOACTs` for more than 1 cycle.

## Structure
- A shared package holds:
  - the FSM state encoding (IDLE, REQ, ACT, DONE, 2 bits);
  - the synchronizer depth constant (2).
- One sub-module, `sync2`: the 2-flop synchronizer with async active-low clear. It is reused for every C16M→FCLK crossing.

## Test plan
- **Reset:** hold `nRES` low with `IOACT = 1`. Required: all outputs at their reset values, and after release no `IOREQ` until `IOACT = 0` plus 2 edges.
- **Posted write:** write with `!nAS`, `IOCS`, `RnW = 0`, `nLDS = 0`, `nUDS = 1`. Required: `nDTACK` low at N+1, `IOREQ = 1`, `IORW = 0`, `IOLDS = 1`, `IOUDS = 0`. Then raise `IOACT` for 6 edges: `IOREQ` falls 3 edges after `IOACT` rises.
- **Read:** drive `IOACT` high 4 edges after `IOREQ`, low 10 edges later. Required: `nDTACK` low exactly 4 edges after `IOACT` falls, and high 1 edge after `nAS` rises.
- **Write then read:** issue a read while the posted write is in ACT. Required: read not accepted and no second `ALE1` until write ACT→IDLE, then one `IOREQ` with `IORW = 1`.
- **Aborted cycle:** `nAS` low for 1 edge with `IOCS` while blocked. Required: no request, no `nDTACK`.
- **Async reset:** assert `nRES` while in REQ. Required: `IOREQ = 0` immediately (asynchronous), state returns to IDLE.

Source files
------------

// File: rtl/io_bus_slave_pkg.sv
// Shared definitions for the CPU-side I/O bus slave front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_bus_slave_pkg;

   // Depth of every C16M -> FCLK synchronizer
   localparam int SYNC_DEPTH = 2;

   // Request handshake states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/io_bus_slave_sync2.sv
// Multi-flop synchronizer for a single C16M-domain level into FCLK, async clear.
// Latency: SYNC_DEPTH FCLK edges from input change to output change.
// Backpressure: none; the input level is sampled every cycle.
module sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);
   import io_bus_slave_pkg::*;

   logic [SYNC_DEPTH-1:0] r_sync;

   // Shift the asynchronous level through the flop chain
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_DEPTH-2:0], i_d};
      end
   end

   assign o_q = r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/io_bus_slave.sv
// CPU I/O cycle front end: posts writes, issues IOREQ level to the C16M bus master, returns nDTACK.
// Latency: accept -> IOREQ/ALE1 (and write nDTACK) 1 edge; read nDTACK 2 edges after synced IOACT falls.
// Backpressure: new I/O cycles are held unacknowledged while a request is outstanding or IOACT is high.
module io_bus_slave (
   input  logic FCLK,
   input  logic nRES,
   input  logic IOCS,
   input  logic nAS,
   input  logic RnW,
   input  logic nUDS,
   input  logic nLDS,
   input  logic IOACT,
   output logic nDTACK,
   output logic IOREQ,
   output logic IORW,
   output logic IOLDS,
   output logic IOUDS,
   output logic ALE1,
   output logic IOBUSY
);
   import io_bus_slave_pkg::*;

   state_t                r_state;
   logic                  r_rd;        // outstanding request is a read
   logic                  r_accepted;  // current CPU cycle already taken
   logic                  r_ready;     // synchronizer has shown a real IOACT low since reset
   logic [SYNC_DEPTH-1:0] r_warm;      // tracks synchronizer refill after reset
   logic                  w_ioacts;
   logic                  w_accept;

   sync2 u_sync_ioact (
      .i_clk   (FCLK),
      .i_rst_n (nRES),
      .i_d     (IOACT),
      .o_q     (w_ioacts)
   );

   assign w_accept = !nAS && IOCS && !r_accepted && r_ready &&
                     (r_state == ST_IDLE) && !w_ioacts;
   assign IOBUSY   = (r_state != ST_IDLE) || w_ioacts;

   // Hold off requests until the cleared synchronizer has refilled and shows the master idle
   always_ff @(posedge FCLK or negedge nRES) begin
      if (!nRES) begin
         r_warm  <= '0;
         r_ready <= 1'b0;
      end else begin
         r_warm  <= {r_warm[SYNC_DEPTH-2:0], 1'b1};
         r_ready <= r_ready || (r_warm[SYNC_DEPTH-1] && !w_ioacts);
      end
   end

   // Request handshake FSM with registered request, latch strobe and acknowledge outputs
   always_ff @(posedge FCLK or negedge nRES) begin
      if (!nRES) begin
         r_state    <= ST_IDLE;
         r_rd       <= 1'b0;
         r_accepted <= 1'b0;
         nDTACK     <= 1'b1;
         IOREQ      <= 1'b0;
         IORW       <= 1'b1;
         IOLDS      <= 1'b0;
         IOUDS      <= 1'b0;
         ALE1       <= 1'b0;
      end else begin
         ALE1 <= 1'b0;
         // End of CPU cycle: re-arm acceptance and release the acknowledge
         if (nAS) begin
            r_accepted <= 1'b0;
            nDTACK     <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state    <= ST_REQ;
                  r_rd       <= RnW;
                  r_accepted <= 1'b1;
                  IOREQ      <= 1'b1;
                  IORW       <= RnW;
                  IOLDS      <= !nLDS;
                  IOUDS      <= !nUDS;
                  ALE1       <= 1'b1;
                  // Writes are posted: acknowledge the CPU right away
                  if (!RnW) begin
                     nDTACK <= 1'b0;
                  end
               end
            end
            ST_REQ: begin
               if (w_ioacts) begin
                  r_state <= ST_ACT;
                  IOREQ   <= 1'b0;
               end
            end
            ST_ACT: begin
               if (!w_ioacts) begin
                  r_state <= r_rd ? ST_DONE : ST_IDLE;
               end
            end
            ST_DONE: begin
               // Read data now sits in the master's input latch
               r_state <= ST_IDLE;
               if (!nAS) begin
                  nDTACK <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_slave.sv
module tb_io_bus_slave;
   logic FCLK = 1'b0;
   logic nRES, IOCS, nAS, RnW, nUDS, nLDS, IOACT;
   logic nDTACK, IOREQ, IORW, IOLDS, IOUDS, ALE1, IOBUSY;

   int n_cmp = 0;
   int n_err = 0;
   int edge_cnt = 0;
   int last_fall = -100;   // edge after which the bench master last dropped IOACT
   bit stop_master = 1'b0;

   always #5 FCLK = ~FCLK;
   always @(posedge FCLK) edge_cnt <= edge_cnt + 1;

   io_bus_slave dut (
      .FCLK(FCLK), .nRES(nRES), .IOCS(IOCS), .nAS(nAS), .RnW(RnW),
      .nUDS(nUDS), .nLDS(nLDS), .IOACT(IOACT),
      .nDTACK(nDTACK), .IOREQ(IOREQ), .IORW(IORW), .IOLDS(IOLDS),
      .IOUDS(IOUDS), .ALE1(ALE1), .IOBUSY(IOBUSY)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge FCLK);
      #1;
   endtask

   task automatic cpu_idle();
      nAS = 1'b1; IOCS = 1'b0; RnW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
   endtask

   task automatic cpu_start(input logic rw, input logic lds, input logic uds);
      nAS = 1'b0; IOCS = 1'b1; RnW = rw; nLDS = !lds; nUDS = !uds;
   endtask

   task automatic do_reset();
      nRES = 1'b0; IOACT = 1'b0; cpu_idle();
      repeat (2) tick();
      nRES = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      int k;
      nRES = 1'b0; IOACT = 1'b1; cpu_idle();
      repeat (3) tick();
      n_cmp++;
      if ({nDTACK, IOREQ, IORW, IOLDS, IOUDS, ALE1, IOBUSY} !== 7'b1010000) begin
         n_err++;
         $display("FAIL reset_values: got %b, expected 1010000", {nDTACK, IOREQ, IORW, IOLDS, IOUDS, ALE1, IOBUSY});
      end
      nRES = 1'b1;
      cpu_start(1'b1, 1'b1, 1'b1);
      repeat (8) begin
         tick();
         n_cmp++;
         if (IOREQ !== 1'b0) begin n_err++; $display("FAIL reset_hold_ioact: IOREQ=%b, expected 0", IOREQ); end
      end
      IOACT = 1'b0;
      repeat (2) begin
         tick();
         n_cmp++;
         if (IOREQ !== 1'b0) begin n_err++; $display("FAIL reset_sync_drain: IOREQ=%b, expected 0", IOREQ); end
      end
      k = 0;
      while (IOREQ !== 1'b1 && k < 10) begin tick(); k++; end
      n_cmp++;
      if (IOREQ !== 1'b1) begin n_err++; $display("FAIL reset_req_after_idle: IOREQ=%b, expected 1", IOREQ); end
      do_reset();
   endtask

   task automatic test_posted_write();
      int k;
      cpu_start(1'b0, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({nDTACK, IOREQ, IORW, IOLDS, IOUDS, ALE1} !== 6'b010101) begin
         n_err++;
         $display("FAIL write_accept: nDTACK/IOREQ/IORW/IOLDS/IOUDS/ALE1=%b, expected 010101", {nDTACK, IOREQ, IORW, IOLDS, IOUDS, ALE1});
      end
      cpu_idle(); IOACT = 1'b1;
      tick();
      n_cmp++;
      if ({nDTACK, ALE1} !== 2'b10) begin n_err++; $display("FAIL write_ack_release: nDTACK/ALE1=%b, expected 10", {nDTACK, ALE1}); end
      k = 1;
      while (IOREQ === 1'b1 && k < 10) begin tick(); k++; end
      n_cmp++;
      if (k != 3) begin n_err++; $display("FAIL write_req_drop: IOREQ fell %0d edges after IOACT, expected 3", k); end
      repeat (3) begin
         tick();
         n_cmp++;
         if (nDTACK !== 1'b1) begin n_err++; $display("FAIL write_no_reack: nDTACK=%b, expected 1", nDTACK); end
      end
      IOACT = 1'b0;
      k = 0;
      while (IOBUSY === 1'b1 && k < 10) begin tick(); k++; end
      n_cmp++;
      if (k != 3) begin n_err++; $display("FAIL write_busy_clear: IOBUSY fell after %0d edges, expected 3", k); end
   endtask

   task automatic test_read();
      int k;
      cpu_start(1'b1, 1'b1, 1'b1);
      tick();
      n_cmp++;
      if ({nDTACK, IOREQ, IORW, IOLDS, IOUDS, ALE1} !== 6'b111111) begin
         n_err++;
         $display("FAIL read_accept: nDTACK/IOREQ/IORW/IOLDS/IOUDS/ALE1=%b, expected 111111", {nDTACK, IOREQ, IORW, IOLDS, IOUDS, ALE1});
      end
      repeat (4) tick();
      IOACT = 1'b1;
      repeat (10) begin
         tick();
         n_cmp++;
         if (nDTACK !== 1'b1) begin n_err++; $display("FAIL read_early_ack: nDTACK=%b, expected 1", nDTACK); end
      end
      IOACT = 1'b0;
      k = 0;
      while (nDTACK === 1'b1 && k < 20) begin tick(); k++; end
      n_cmp++;
      if (k != 4) begin n_err++; $display("FAIL read_ack_timing: nDTACK fell %0d edges after IOACT, expected 4", k); end
      repeat (2) begin
         tick();
         n_cmp++;
         if ({nDTACK, IOREQ, ALE1} !== 3'b000) begin n_err++; $display("FAIL read_ack_hold: nDTACK/IOREQ/ALE1=%b, expected 000", {nDTACK, IOREQ, ALE1}); end
      end
      cpu_idle();
      tick();
      n_cmp++;
      if ({nDTACK, IOBUSY} !== 2'b10) begin n_err++; $display("FAIL read_ack_release: nDTACK/IOBUSY=%b, expected 10", {nDTACK, IOBUSY}); end
   endtask

   task automatic test_write_then_read();
      int k;
      cpu_start(1'b0, 1'b0, 1'b1);
      tick();
      cpu_idle(); IOACT = 1'b1;
      tick();
      repeat (2) tick();
      n_cmp++;
      if (IOREQ !== 1'b0) begin n_err++; $display("FAIL wr_rd_in_act: IOREQ=%b, expected 0", IOREQ); end
      cpu_start(1'b1, 1'b1, 1'b1);
      repeat (4) begin
         tick();
         n_cmp++;
         if ({ALE1, nDTACK} !== 2'b01) begin n_err++; $display("FAIL wr_rd_blocked: ALE1/nDTACK=%b, expected 01", {ALE1, nDTACK}); end
      end
      IOACT = 1'b0;
      k = 0;
      while (ALE1 !== 1'b1 && k < 10) begin tick(); k++; end
      n_cmp++;
      if (k != 4) begin n_err++; $display("FAIL wr_rd_accept_edge: read accepted %0d edges after IOACT fell, expected 4", k); end
      n_cmp++;
      if ({IOREQ, IORW} !== 2'b11) begin n_err++; $display("FAIL wr_rd_request: IOREQ/IORW=%b, expected 11", {IOREQ, IORW}); end
      repeat (2) tick();
      IOACT = 1'b1;
      repeat (5) tick();
      IOACT = 1'b0;
      k = 0;
      while (nDTACK === 1'b1 && k < 20) begin tick(); k++; end
      n_cmp++;
      if (nDTACK !== 1'b0) begin n_err++; $display("FAIL wr_rd_read_ack: nDTACK=%b, expected 0", nDTACK); end
      cpu_idle();
      tick();
   endtask

   task automatic test_aborted();
      int n_ale, n_ack, n_req;
      n_ale = 0; n_ack = 0; n_req = 0;
      cpu_start(1'b0, 1'b1, 1'b1);
      tick();
      cpu_idle(); IOACT = 1'b1;
      tick();
      repeat (2) tick();
      cpu_start(1'b1, 1'b1, 1'b1);
      tick();
      n_ale += int'(ALE1 === 1'b1); n_ack += int'(nDTACK === 1'b0); n_req += int'(IOREQ === 1'b1);
      cpu_idle();
      repeat (2) begin
         tick();
         n_ale += int'(ALE1 === 1'b1); n_ack += int'(nDTACK === 1'b0); n_req += int'(IOREQ === 1'b1);
      end
      IOACT = 1'b0;
      repeat (10) begin
         tick();
         n_ale += int'(ALE1 === 1'b1); n_ack += int'(nDTACK === 1'b0); n_req += int'(IOREQ === 1'b1);
      end
      n_cmp++;
      if (n_ale != 0 || n_req != 0) begin n_err++; $display("FAIL abort_no_request: ALE1 seen %0d, IOREQ seen %0d, expected 0 and 0", n_ale, n_req); end
      n_cmp++;
      if (n_ack != 0) begin n_err++; $display("FAIL abort_no_ack: nDTACK low %0d cycles, expected 0", n_ack); end
      n_cmp++;
      if (IOBUSY !== 1'b0) begin n_err++; $display("FAIL abort_idle: IOBUSY=%b, expected 0", IOBUSY); end
   endtask

   task automatic test_async_reset();
      cpu_start(1'b1, 1'b1, 1'b1);
      tick();
      n_cmp++;
      if (IOREQ !== 1'b1) begin n_err++; $display("FAIL arst_in_req: IOREQ=%b, expected 1", IOREQ); end
      #3;
      nRES = 1'b0;
      #1;
      n_cmp++;
      if ({IOREQ, IOBUSY, nDTACK, ALE1, IORW} !== 5'b00101) begin
         n_err++;
         $display("FAIL arst_immediate: IOREQ/IOBUSY/nDTACK/ALE1/IORW=%b, expected 00101", {IOREQ, IOBUSY, nDTACK, ALE1, IORW});
      end
      tick();
      cpu_idle();
      nRES = 1'b1;
      repeat (4) tick();
      cpu_start(1'b0, 1'b1, 1'b1);
      tick();
      n_cmp++;
      if ({ALE1, IOREQ, nDTACK} !== 3'b110) begin n_err++; $display("FAIL arst_back_idle: ALE1/IOREQ/nDTACK=%b, expected 110", {ALE1, IOREQ, nDTACK}); end
      cpu_idle(); IOACT = 1'b1;
      repeat (6) tick();
      IOACT = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if (IOBUSY !== 1'b0) begin n_err++; $display("FAIL arst_recover_idle: IOBUSY=%b, expected 0", IOBUSY); end
   endtask

   // Random CPU cycles against a random-latency bus master; every cycle must be
   // accepted once, in order, with the right lanes and a single acknowledge.
   task automatic test_random();
      stop_master = 1'b0;
      last_fall = -100;
      fork
         begin
            for (int t = 0; t < 40; t++) begin
               logic rw, lds, uds;
               int issue, exp_acc, n_ale, k;
               bit acked;
               rw = 1'($urandom_range(0, 1));
               lds = 1'($urandom_range(0, 1));
               uds = 1'($urandom_range(0, 1));
               repeat ($urandom_range(0, 3)) begin
                  tick();
                  n_cmp++;
                  if (nDTACK !== 1'b1) begin n_err++; $display("FAIL rnd_idle_ack: txn %0d nDTACK=%b, expected 1", t, nDTACK); end
               end
               cpu_start(rw, lds, uds);
               issue = edge_cnt; n_ale = 0; acked = 1'b0; k = 0;
               while (!acked && k < 200) begin
                  tick(); k++;
                  if (ALE1 === 1'b1) begin
                     n_ale++;
                     exp_acc = (issue + 1 > last_fall + 4) ? issue + 1 : last_fall + 4;
                     n_cmp++;
                     if (edge_cnt != exp_acc) begin n_err++; $display("FAIL rnd_accept_edge: txn %0d accepted at edge %0d, expected %0d", t, edge_cnt, exp_acc); end
                     n_cmp++;
                     if ({IOREQ, IORW, IOLDS, IOUDS} !== {1'b1, rw, lds, uds}) begin
                        n_err++;
                        $display("FAIL rnd_lanes: txn %0d IOREQ/IORW/IOLDS/IOUDS=%b, expected %b", t, {IOREQ, IORW, IOLDS, IOUDS}, {1'b1, rw, lds, uds});
                     end
                  end
                  if (nDTACK === 1'b0) begin
                     acked = 1'b1;
                     n_cmp++;
                     if (rw == 1'b0) begin
                        if (n_ale != 1 || ALE1 !== 1'b1) begin n_err++; $display("FAIL rnd_write_ack: txn %0d ack with ALE1=%b after %0d accepts, expected posted on accept", t, ALE1, n_ale); end
                     end else begin
                        if (n_ale != 1 || edge_cnt != last_fall + 4) begin n_err++; $display("FAIL rnd_read_ack: txn %0d ack at edge %0d (%0d accepts), expected edge %0d", t, edge_cnt, n_ale, last_fall + 4); end
                     end
                  end
               end
               if (!acked) begin n_err++; n_cmp++; $display("FAIL rnd_ack_timeout: txn %0d no nDTACK within 200 edges", t); end
               cpu_idle();
               tick();
               n_cmp++;
               if (nDTACK !== 1'b1) begin n_err++; $display("FAIL rnd_ack_release: txn %0d nDTACK=%b, expected 1", t, nDTACK); end
            end
            begin
               int k;
               k = 0;
               while (IOBUSY !== 1'b0 && k < 100) begin tick(); k++; end
               n_cmp++;
               if (IOBUSY !== 1'b0) begin n_err++; $display("FAIL rnd_final_idle: IOBUSY=%b, expected 0", IOBUSY); end
            end
            stop_master = 1'b1;
         end
         begin
            while (!stop_master) begin
               tick();
               if (IOREQ === 1'b1 && IOACT === 1'b0) begin
                  int d, h;
                  logic exp_req;
                  d = $urandom_range(0, 3);
                  h = $urandom_range(3, 7);
                  repeat (d) tick();
                  IOACT = 1'b1;
                  for (int i = 1; i <= h; i++) begin
                     tick();
                     exp_req = (i < 3);
                     n_cmp++;
                     if (IOREQ !== exp_req) begin n_err++; $display("FAIL rnd_req_drop: %0d edges after IOACT IOREQ=%b, expected %b", i, IOREQ, exp_req); end
                  end
                  IOACT = 1'b0;
                  last_fall = edge_cnt;
               end
            end
         end
      join
   endtask

   initial begin
      cpu_idle();
      IOACT = 1'b0;
      nRES = 1'b0;
      test_reset();
      test_posted_write();
      test_read();
      test_write_then_read();
      test_aborted();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
